adder_4bit: RTL and testbench

- Registered ripple-carry adder: computes s = a + b + cin, with carry-out and two's-complement overflow flag.
- Width is parameterised; the default is 4 bits.
- Datapath arithmetic leaf block. Built from a chain of 1-bit full-adder cells, with the result captured in output registers on the rising clock edge.

---
 rtl/adder_4bit.sv | 50 +++++
 tb/tb_adder_4bit.sv | 119 +++++++++++
 2 files changed

// File: rtl/adder_4bit.sv
// Purpose: registered ripple-carry adder, s = a + b + cin, with carry-out and signed-overflow flags.
// Latency: 1 core clock; operands sampled on edge N appear on s/cout/ovf after edge N, one result per cycle.
// Backpressure: none; free-running datapath with no handshake, so every cycle yields a new result.
module adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB cell
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             ovf_nxt;

  // Ripple chain: each loop iteration is one full-adder cell fed by the previous carry
  always_comb begin
    c       = '0;
    sum_nxt = '0;
    c[0]    = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_nxt[i] = a[i] ^ b[i] ^ c[i];
      c[i+1]     = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout_nxt = c[WIDTH];
    // Signed overflow: carry into the MSB disagrees with carry out of the MSB
    ovf_nxt  = c[WIDTH] ^ c[WIDTH-1];
  end

  // Output registers; reset wins over the incoming operands and drops any pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      s    <= sum_nxt;
      cout <= cout_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
module tb_adder_4bit;

  logic       clk;
  logic       rst;
  logic       cin;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic       cout;
  logic       ovf;

  int passes;
  int total;

  adder_4bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .cin  (cin),
    .a    (a),
    .b    (b),
    .s    (s),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] s_exp, input logic cout_exp, input logic ovf_exp);
    total++;
    assert (s === s_exp) passes++;
    else $error("FAIL %s s: got %b expected %b", tag, s, s_exp);
    total++;
    assert (cout === cout_exp) passes++;
    else $error("FAIL %s cout: got %b expected %b", tag, cout, cout_exp);
    total++;
    assert (ovf === ovf_exp) passes++;
    else $error("FAIL %s ovf: got %b expected %b", tag, ovf, ovf_exp);
  endtask

  // Present operands, take exactly one rising edge, sample 1 time unit after it
  task automatic step(input logic [3:0] va, input logic [3:0] vb, input logic vc);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] ref_sum;
    logic       ref_ovf;
    logic [3:0] va;
    logic [3:0] vb;
    passes = 0;
    total  = 0;

    // Reset held two cycles with all-ones operands
    rst = 1'b1;
    step(4'b1111, 4'b1111, 1'b1);
    check("reset_1", 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b1111, 1'b1);
    check("reset_2", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(4'b1111, 4'b1111, 1'b1);
    check("post_reset", 4'b1111, 1'b1, 1'b0);

    // Back-to-back directed vectors, new operands every cycle
    step(4'b0011, 4'b0001, 1'b0);
    check("add_3_1", 4'b0100, 1'b0, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    check("add_1_1", 4'b0010, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    check("add_0_0", 4'b0000, 1'b0, 1'b0);
    step(4'b0101, 4'b0111, 1'b0);
    check("ovf_5_7", 4'b1100, 1'b0, 1'b1);
    step(4'b0101, 4'b0111, 1'b1);
    check("ovf_5_7_cin", 4'b1101, 1'b0, 1'b1);
    step(4'b1111, 4'b0001, 1'b0);
    check("wrap_f_1", 4'b0000, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    check("wrap_f_f", 4'b1110, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    check("cin_0_0", 4'b0001, 1'b0, 1'b0);
    step(4'b0010, 4'b0001, 1'b1);
    check("cin_2_1", 4'b0100, 1'b0, 1'b0);
    step(4'b1111, 4'b0001, 1'b1);
    check("cin_f_1", 4'b0001, 1'b1, 1'b0);
    // Both flags set together: -8 + -8 = 0 with carry-out
    step(4'b1000, 4'b1000, 1'b0);
    check("both_flags", 4'b0000, 1'b1, 1'b1);

    // Mid-stream reset discards the operands presented at that edge
    rst = 1'b1;
    step(4'b0110, 4'b0011, 1'b0);
    check("mid_reset", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(4'b0110, 4'b0011, 1'b0);
    check("after_mid_reset", 4'b1001, 1'b0, 1'b1);

    // Exhaustive sweep against the arithmetic sum and the sign rule
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          va      = 4'(ia);
          vb      = 4'(ib);
          ref_sum = 5'(ia) + 5'(ib) + 5'(ic);
          ref_ovf = (va[3] == vb[3]) && (ref_sum[3] != va[3]);
          step(va, vb, 1'(ic));
          check($sformatf("sweep_%0d_%0d_%0d", ia, ib, ic), ref_sum[3:0], ref_sum[4], ref_ovf);
        end
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
